// File: rtl/apa102_pkg.sv
// Shared types and constants for the APA102 frame transmitter.
package apa102_pkg;

    localparam int unsigned START_BITS = 32;
    localparam logic [2:0]  LED_HDR    = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_FRM,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT_LED,
        ST_END_FRM
    } state_e;

    // End frame needs one clock edge per two LEDs; one 32-bit word covers 64 LEDs.
    function automatic int unsigned end_words(input int unsigned num_leds);
        return (num_leds + 32'd63) / 32'd64;
    endfunction

endpackage

// File: rtl/apa102_shifter.sv
// 32-bit word serializer: SCLK phase divider, bit counter and MSB-first shift register.
module apa102_shifter
    import apa102_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [START_BITS-1:0] word,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  word_done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(START_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(START_BITS - 1);

    logic                  active_q, active_d;
    logic [START_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  word_done_q, word_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            word_done_q <= word_done_d;
        end
    end

    // A load restarts the low phase, so mosi only moves while sclk is (or goes) low.
    always_comb begin
        active_d  = active_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        if (load) begin
            active_d  = 1'b1;
            shreg_d   = word;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            mosi_d    = word[START_BITS-1];
        end else if (active_q) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        active_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shreg_d   = {shreg_q[START_BITS-2:0], 1'b0};
                        mosi_d    = shreg_q[START_BITS-2];
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
        // Flag the last cycle of the final high phase so the next word can load with no gap.
        word_done_d = active_d && sclk_d && (bit_cnt_d == BIT_LAST) && (div_cnt_d == DIV_LAST);
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign word_done = word_done_q;

endmodule

// File: rtl/apa102_frame_tx.sv
// APA102 frame transmitter: latches a frame index, fetches its pixel words and streams them to the strip.
module apa102_frame_tx
    import apa102_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned FRAME_BASE = 0,
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [4:0]  BRIGHTNESS = 5'd31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            frame_idx,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned END_WORDS = end_words(NUM_LEDS);
    localparam int unsigned LED_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned END_W     = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;
    localparam int unsigned PROD_W    = ADDR_WIDTH + 8;
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
    localparam logic [END_W-1:0] END_LAST = END_W'(END_WORDS - 1);
    localparam logic [START_BITS-1:0] ONES = '1;

    // Computed wide, then truncated: out-of-range frames wrap silently.
    function automatic logic [ADDR_WIDTH-1:0] led_addr(input logic [7:0] frame,
                                                       input logic [LED_W-1:0] led);
        logic [PROD_W-1:0] sum;
        sum = PROD_W'(FRAME_BASE) + PROD_W'(frame) * PROD_W'(NUM_LEDS) + PROD_W'(led);
        return ADDR_WIDTH'(sum);
    endfunction

    state_e                state_q, state_d;
    logic [7:0]            frame_q, frame_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [END_W-1:0]      end_cnt_q, end_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load_c;
    logic [START_BITS-1:0] word_c;
    logic                  word_done;
    logic                  unused_hi;

    assign unused_hi = ^mem_data[31:24];

    apa102_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .word      (word_c),
        .sclk      (sclk),
        .mosi      (mosi),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            led_q      <= '0;
            end_cnt_q  <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            led_q      <= led_d;
            end_cnt_q  <= end_cnt_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Address is registered on entry to FETCH so the memory sees it during FETCH and answers in WAIT.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        led_d      = led_q;
        end_cnt_d  = end_cnt_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
        word_c     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d = frame_idx;
                    led_d   = '0;
                    load_c  = 1'b1;
                    word_c  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_START_FRM;
                end
            end
            ST_START_FRM: begin
                if (word_done) begin
                    mem_addr_d = led_addr(frame_q, led_q);
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                load_c  = 1'b1;
                word_c  = {LED_HDR, BRIGHTNESS, mem_data[7:0], mem_data[15:8], mem_data[23:16]};
                state_d = ST_SHIFT_LED;
            end
            ST_SHIFT_LED: begin
                if (word_done) begin
                    if (led_q == LED_LAST) begin
                        load_c    = 1'b1;
                        word_c    = ONES;
                        end_cnt_d = '0;
                        state_d   = ST_END_FRM;
                    end else begin
                        led_d      = led_q + LED_W'(1);
                        mem_addr_d = led_addr(frame_q, led_d);
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_END_FRM: begin
                if (word_done) begin
                    if (end_cnt_q == END_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        end_cnt_d = end_cnt_q + END_W'(1);
                        load_c    = 1'b1;
                        word_c    = ONES;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/apa102_frame_tx.md
# apa102_frame_tx

Frame-streaming transmitter on the consumer side of the MMIO frame-index register. When `start` is pulsed, normally by the 24 fps tick, it latches the current `frame_idx` and reads that frame's pixel words from the frame memory. Each pixel is serialized onto an APA102 LED strip as start frame, per-LED words, then end frame. It sits between the processor-written frame index, the frame memory read port, and the strip's SCLK/MOSI pins.

## Interface
- `NUM_LEDS`, 64: LEDs per strip, and words per frame in memory.
- `ADDR_WIDTH`, 12: frame memory address width.
- `FRAME_BASE`, 0: word address of frame 0.
- `CLK_DIV`, 4: clk cycles per SCLK half-period; must be ≥1.
- `BRIGHTNESS`, 5'd31: global brightness field in every LED word.

- `clk` in 1: system clock; one clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to send one frame.
- `frame_idx` in 8: frame to send; sampled only when `start` is accepted.
- `mem_addr` out ADDR_WIDTH: frame memory read address.
- `mem_data` in 32: read data, valid one cycle after `mem_addr`. Bits [23:16]=R, [15:8]=G, [7:0]=B; [31:24] ignored.
- `sclk` out 1: strip clock; idles low.
- `mosi` out 1: strip data, MSB first.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- Reset values (asynchronous, all outputs): `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `mem_addr`=0. The FSM resets to IDLE.
- FSM states: IDLE → START_FRM → FETCH → WAIT → SHIFT_LED → (FETCH, or END_FRM after the last LED) → IDLE.
- **IDLE**
  - `start`=1 latches `frame_idx` and loads 32'h0.
  - The FSM then goes to START_FRM.
- **START_FRM**: shifts out 32 zero bits.
- **FETCH**
  - Drives `mem_addr` = (FRAME_BASE + frame_idx_latched*NUM_LEDS + led) mod 2^ADDR_WIDTH.
  - The product is computed at ADDR_WIDTH+8 bits before truncation, so addresses wrap silently.
- **WAIT**: captures `mem_data` and loads {3'b111, BRIGHTNESS, B, G, R}.
- **SHIFT_LED**
  - Shifts out 32 bits.
  - `led` increments after each word, from 0 to NUM_LEDS-1.
- **END_FRM**: shifts out END_WORDS = ceil(NUM_LEDS/64) words of 32'hFFFFFFFF.
- **Completion**: after the final bit's high phase, the FSM returns to IDLE, `busy` drops, and `done` pulses for that one cycle.
- **`start` handling**
  - `start` while `busy` is ignored; it is not queued.
  - `start` in the `done` cycle is accepted, since the state is already IDLE.
- `frame_idx` changes during a frame have no effect on that frame.
- `mem_addr` holds its last value outside FETCH.
- Reset mid-frame aborts immediately and leaves the strip mid-word. The next frame's 32-zero start frame resynchronizes the strip, so no recovery logic is required.

## Timing
- **Bit cell**: `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
- **`mosi` changes** only when `sclk` falls, or at a word load while `sclk` is low. It is stable for CLK_DIV cycles before and during every `sclk` high phase.
- **Word load to first rising edge**: CLK_DIV cycles.
- **Between words**
  - There is no gap between START_FRM and FETCH entry.
  - Each LED word adds exactly 2 cycles (FETCH, WAIT) with `sclk` held low.
- **Total frame cycles** from the cycle after `start` to `done`: 2·CLK_DIV·32·(1+NUM_LEDS+END_WORDS) + 2·NUM_LEDS.
- **Status latency**: `busy` rises the cycle after `start` is accepted.

## Structure
- **Shared package** (`apa102_pkg`):
  - State enum.
  - START_BITS=32 and LED_HDR=3'b111.
  - An END_WORDS function of NUM_LEDS.
- **Sub-module** `apa102_shifter`:
  - 32-bit load/shift register, SCLK phase divider and bit counter.
  - Inputs: `load`, `word`.
  - Outputs: `sclk`, `mosi`, `word_done`.
  - The top level holds the FSM, address generation and frame latch.

## Test plan
All scenarios use NUM_LEDS=2 and CLK_DIV=2 unless stated.
1. **Reset**: assert `rst_n`=0 mid-simulation, asynchronously → all outputs 0 within the same cycle; IDLE after release.
2. **Frame contents**
   - Stimulus: `start` with `frame_idx`=3; memory returns 0x00FF8040 at 6 and 0x00010203 at 7.
   - Required `mem_addr` sequence: 6, 7.
   - Required `mosi` words: 0x00000000, 0xFF4080FF, 0xFF030201, 0xFFFFFFFF.
   - Required completion: a single `done` pulse; frame length 2·2·32·4+4 = 516 cycles.
3. **Bit timing**: same frame → `sclk` period exactly 4 cycles within words; `mosi` never toggles while `sclk`=1; 2 low-`sclk` cycles before each LED word.
4. **Start handling**: `start` mid-frame, and `frame_idx` changed to 9 mid-frame → second `start` ignored, addresses stay 6/7, exactly one `done`. A `start` in the `done` cycle begins a new frame.
5. **Reset recovery**: reset at bit 40 of frame 3 → lines low immediately; the next `start` produces a complete, correct 128-bit frame.
6. **Address wrap**: NUM_LEDS=64, ADDR_WIDTH=12, `frame_idx`=255 → first `mem_addr` is 4032 (16320 mod 4096), last is 4095; END_WORDS=1.
